// File: rtl/uarr_l2_wfetch.sv
// uarr_l2_wfetch: weight-fetch sequencer for the layer-2 unrolled array.
// It issues even base addresses to the 16 dual-port weight ROMs and tracks the
// fixed read latency of each fetch. Returned 32-word rows are buffered in a
// small FIFO and handed to the MAC array over valid/ready.
// Optional build macro UARR_L2_WFETCH_STALL_CNT_EN adds a saturating 16-bit
// stall counter output (stall_cnt).
module uarr_l2_wfetch #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LANES      = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              start_addr,
  input  logic [ADDR_W-1:0]              num_beats,
  output logic [ADDR_W-1:0]              addr_base,
  input  logic [LANES-1:0][DATA_W-1:0]   mem_dout,
  output logic                           w_valid,
  input  logic                           w_ready,
  output logic [LANES-1:0][DATA_W-1:0]   w_data,
  output logic                           w_last,
  output logic                           busy,
  output logic                           done
`ifdef UARR_L2_WFETCH_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                         last;
    logic [LANES-1:0][DATA_W-1:0] data;
  } row_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;     // next address to issue
  logic [ADDR_W-1:0]   num_q, num_d;
  logic [ADDR_W-1:0]   iss_q, iss_d;
  logic [ADDR_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]   abase_q, abase_d;
  // stage 0 loads on the edge addr_base changes; stage RD_LAT lines up with
  // the cycle the ROM output for that address is valid
  logic [RD_LAT:0]     vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:0]     lst_pipe_q, lst_pipe_d;
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]         cnt_q, cnt_d;
  row_t                fifo_mem [FIFO_DEPTH];

  logic                start_ok, issue, iss_last, pop, fifo_wr, credit;
  logic [CW-1:0]       inflight, occ;
  logic [ADDR_W-1:0]   iss_addr, iss_base, nb_eff;
  row_t                head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // handshake, credit and issue decisions
  always_comb begin
    start_ok = (state_q == IDLE) && start;
    pop      = w_valid && w_ready;
    fifo_wr  = vld_pipe_q[RD_LAT];
    inflight = CW'($countones(vld_pipe_q));
    occ      = CW'(cnt_q) + inflight - CW'(pop);
    credit   = occ < CW'(FIFO_DEPTH);
    iss_addr = (state_q == IDLE) ? {start_addr[ADDR_W-1:1], 1'b0} : addr_q;
    iss_base = (state_q == IDLE) ? '0 : iss_q;
    nb_eff   = (state_q == IDLE) ? num_beats : num_q;
    iss_last = (iss_base + ADDR_W'(1)) == nb_eff;
    // the first row issues on the same edge that accepts start
    issue    = (start_ok && (num_beats != '0)) ||
               ((state_q == RUN) && (iss_q < num_q) && credit);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (num_beats != '0) ? RUN : DONE;
      RUN:   if (iss_q == num_q) state_d = DRAIN;
      DRAIN: if (((acc_q + ADDR_W'(pop)) == num_q) && (inflight == '0)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // sequence counters, address generation, in-flight tracker, FIFO pointers
  always_comb begin
    addr_d     = addr_q;
    num_d      = num_q;
    iss_d      = iss_q;
    acc_d      = acc_q;
    abase_d    = abase_q;
    vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], issue};
    lst_pipe_d = {lst_pipe_q[RD_LAT-1:0], issue && iss_last};
    rd_d       = pop     ? ptr_inc(rd_q) : rd_q;
    wr_d       = fifo_wr ? ptr_inc(wr_q) : wr_q;
    cnt_d      = cnt_q + (PW+1)'(fifo_wr) - (PW+1)'(pop);
    if (start_ok) begin
      num_d  = num_beats;
      iss_d  = '0;
      acc_d  = '0;
      addr_d = iss_addr;
    end
    if (issue) begin
      abase_d = iss_addr;
      addr_d  = iss_addr + ADDR_W'(2);
      iss_d   = iss_base + ADDR_W'(1);
    end
    if (pop) acc_d = acc_q + ADDR_W'(1);
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q     <= '0;
      num_q      <= '0;
      iss_q      <= '0;
      acc_q      <= '0;
      abase_q    <= '0;
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      num_q      <= num_d;
      iss_q      <= iss_d;
      acc_q      <= acc_d;
      abase_q    <= abase_d;
      vld_pipe_q <= vld_pipe_d;
      lst_pipe_q <= lst_pipe_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end

  // row storage: captures the ROM bank when the oldest in-flight read lands
  always_ff @(posedge clk)
    if (fifo_wr) fifo_mem[wr_q] <= '{last: lst_pipe_q[RD_LAT], data: mem_dout};

  // downstream view of the FIFO head; zeroed while empty so reset clears it
  always_comb begin
    head      = fifo_mem[rd_q];
    addr_base = abase_q;
    w_valid   = (cnt_q != '0);
    w_data    = w_valid ? head.data : '0;
    w_last    = w_valid && head.last;
  end

`ifdef UARR_L2_WFETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // saturating count of backpressured cycles, cleared by an accepted start
  always_comb begin
    stall_d = stall_q;
    if (start_ok) stall_d = '0;
    else if (w_valid && !w_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // stall counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;

  assign stall_cnt = stall_q;
`endif

  // credit must keep the row buffer from ever being written while full
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && (cnt_q == (PW+1)'(FIFO_DEPTH))));

endmodule
